// File: rtl/fb_write_arbiter_if.sv
// Pixel write bus between the draw sources and the frame buffer port.
// master: draw units and frame buffer; slave: the write arbiter.
interface fb_write_arbiter_if #(
    parameter int NUM_SOURCES = 4,
    parameter int COLOR_DEPTH = 9,
    parameter int COORD_W     = 11
);
    logic [NUM_SOURCES-1:0]             src_valid;
    logic [NUM_SOURCES-1:0]             src_done;
    logic [NUM_SOURCES*COLOR_DEPTH-1:0] src_color;
    logic [NUM_SOURCES*COORD_W-1:0]     src_x;
    logic [NUM_SOURCES*COORD_W-1:0]     src_y;
    logic [NUM_SOURCES-1:0]             src_transparent;
    logic [NUM_SOURCES-1:0]             src_grant;
    logic                               fb_ready;
    logic                               fb_we;
    logic [COORD_W-1:0]                 fb_x;
    logic [COORD_W-1:0]                 fb_y;
    logic [COLOR_DEPTH-1:0]             fb_color;

    modport master (
        output src_valid, src_done, src_color, src_x, src_y,
        output src_transparent, fb_ready,
        input  src_grant, fb_we, fb_x, fb_y, fb_color
    );

    modport slave (
        input  src_valid, src_done, src_color, src_x, src_y,
        input  src_transparent, fb_ready,
        output src_grant, fb_we, fb_x, fb_y, fb_color
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// N-source frame buffer write arbiter: layered or round-robin grant,
// with clipping, transparency drop, overrun flag and per-frame counters.
module fb_write_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int COLOR_DEPTH = 9,
    parameter int COORD_W     = 11,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int MODE        = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame,
    fb_write_arbiter_if.slave   bus,
    output logic                busy,
    output logic                frame_complete,
    output logic                overrun,
    output logic [15:0]         write_count,
    output logic [15:0]         drop_count
);
    localparam int CW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam logic [CW-1:0] LAST_SRC = CW'(NUM_SOURCES - 1);
    localparam logic [NUM_SOURCES-1:0] G0 = NUM_SOURCES'(1);
    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SERVE = 1'b1;

    logic [0:0]             state;
    logic [CW-1:0]          cur;
    logic [CW-1:0]          ptr;
    logic [CW-1:0]          acc_idx;
    logic [CW-1:0]          rr_start;
    logic [NUM_SOURCES-1:0] grant;
    logic [NUM_SOURCES-1:0] rr_grant;
    logic                   rr_found;
    logic [15:0]            wr_cnt, dr_cnt, wr_nxt, dr_nxt;
    logic                   acc, pix_ok, wr_inc, dr_inc;
    logic                   done_cur, hold;
    logic [COLOR_DEPTH-1:0] sel_color;
    logic [COORD_W-1:0]     sel_x, sel_y;
    logic                   sel_tr;

    function automatic logic [15:0] sat_inc(input logic [15:0] c,
                                            input logic inc);
        return (inc && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction

    assign bus.src_grant = grant;
    assign acc    = (|(bus.src_valid & grant)) & bus.fb_ready;
    assign hold   = |(bus.src_valid & grant);
    assign pix_ok = !sel_tr && (sel_x < X_LIM) && (sel_y < Y_LIM);
    assign wr_inc = acc & pix_ok;
    assign dr_inc = acc & ~pix_ok;
    assign wr_nxt = sat_inc(wr_cnt, wr_inc);
    assign dr_nxt = sat_inc(dr_cnt, dr_inc);
    assign done_cur = bus.src_done[cur] & grant[cur];

    // grant is one-hot, so the granted source is also the accepted one
    always_comb begin
        acc_idx   = '0;
        sel_color = '0;
        sel_x     = '0;
        sel_y     = '0;
        sel_tr    = 1'b0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (grant[k]) begin
                acc_idx   = CW'(k);
                sel_color = bus.src_color[k*COLOR_DEPTH +: COLOR_DEPTH];
                sel_x     = bus.src_x[k*COORD_W +: COORD_W];
                sel_y     = bus.src_y[k*COORD_W +: COORD_W];
                sel_tr    = bus.src_transparent[k];
            end
        end
    end

    // round-robin search begins just after the last accepted source
    always_comb begin
        if (acc)
            rr_start = (acc_idx == LAST_SRC) ? '0 : acc_idx + 1'b1;
        else
            rr_start = ptr;
        rr_grant = '0;
        rr_found = 1'b0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (!rr_found &&
                bus.src_valid[(int'(rr_start) + i) % NUM_SOURCES]) begin
                rr_grant[(int'(rr_start) + i) % NUM_SOURCES] = 1'b1;
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cur            <= '0;
            ptr            <= '0;
            grant          <= '0;
            wr_cnt         <= '0;
            dr_cnt         <= '0;
            busy           <= 1'b0;
            frame_complete <= 1'b0;
            overrun        <= 1'b0;
            write_count    <= '0;
            drop_count     <= '0;
            bus.fb_we      <= 1'b0;
            bus.fb_x       <= '0;
            bus.fb_y       <= '0;
            bus.fb_color   <= '0;
        end else begin
            bus.fb_we      <= wr_inc;
            frame_complete <= 1'b0;
            wr_cnt         <= wr_nxt;
            dr_cnt         <= dr_nxt;
            if (acc) begin
                bus.fb_x     <= sel_x;
                bus.fb_y     <= sel_y;
                bus.fb_color <= sel_color;
            end
            if (MODE == 1) begin
                busy  <= 1'b0;
                state <= IDLE;
                if (acc)
                    ptr <= rr_start;
                if (acc || !hold)
                    grant <= rr_grant;
                if (frame) begin
                    frame_complete <= 1'b1;
                    write_count    <= wr_nxt;
                    drop_count     <= dr_nxt;
                    wr_cnt         <= '0;
                    dr_cnt         <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        grant <= '0;
                        if (frame) begin
                            state  <= SERVE;
                            busy   <= 1'b1;
                            cur    <= '0;
                            grant  <= G0;
                            wr_cnt <= '0;
                            dr_cnt <= '0;
                        end
                    end
                    SERVE: begin
                        if (done_cur && cur == LAST_SRC) begin
                            frame_complete <= 1'b1;
                            write_count    <= wr_nxt;
                            drop_count     <= dr_nxt;
                            wr_cnt         <= '0;
                            dr_cnt         <= '0;
                            cur            <= '0;
                            // a coincident frame starts the next pass at once
                            if (frame) begin
                                grant <= G0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                grant <= '0;
                            end
                        end else if (frame) begin
                            overrun <= 1'b1;
                            cur     <= '0;
                            grant   <= G0;
                            wr_cnt  <= '0;
                            dr_cnt  <= '0;
                        end else if (done_cur) begin
                            cur   <= cur + 1'b1;
                            grant <= G0 << (cur + 1'b1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench: a 2-source layered arbiter and a 4-source
// round-robin arbiter sharing clock and reset.
module tb_fb_write_arbiter;
    logic clk;
    logic reset;
    logic lframe, rframe;
    logic lbusy, lfc, lovr;
    logic rbusy, rfc, rovr;
    logic [15:0] lwc, ldc, rwc, rdc;
    int tests = 0;
    int fails = 0;
    int exp_g [8] = '{1, 4, 8, 1, 4, 8, 1, 4};
    int exp_i [8] = '{0, 2, 3, 0, 2, 3, 0, 2};

    fb_write_arbiter_if #(.NUM_SOURCES(2), .COLOR_DEPTH(9),
                          .COORD_W(11)) lb ();
    fb_write_arbiter_if #(.NUM_SOURCES(4), .COLOR_DEPTH(9),
                          .COORD_W(11)) rb ();

    fb_write_arbiter #(
        .NUM_SOURCES(2), .COLOR_DEPTH(9), .COORD_W(11),
        .SCREEN_W(640), .SCREEN_H(480), .MODE(0)
    ) u_lay (
        .clk(clk), .reset(reset), .frame(lframe), .bus(lb.slave),
        .busy(lbusy), .frame_complete(lfc), .overrun(lovr),
        .write_count(lwc), .drop_count(ldc)
    );

    fb_write_arbiter #(
        .NUM_SOURCES(4), .COLOR_DEPTH(9), .COORD_W(11),
        .SCREEN_W(640), .SCREEN_H(480), .MODE(1)
    ) u_rr (
        .clk(clk), .reset(reset), .frame(rframe), .bus(rb.slave),
        .busy(rbusy), .frame_complete(rfc), .overrun(rovr),
        .write_count(rwc), .drop_count(rdc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic lpix(input int k, input int x, input int y,
                        input logic [8:0] c, input logic tr);
        lb.src_valid = '0;
        lb.src_transparent = '0;
        lb.src_valid[k] = 1'b1;
        lb.src_transparent[k] = tr;
        lb.src_x[k*11 +: 11] = 11'(x);
        lb.src_y[k*11 +: 11] = 11'(y);
        lb.src_color[k*9 +: 9] = c;
    endtask

    task automatic lidle();
        lb.src_valid = '0;
        lb.src_transparent = '0;
    endtask

    initial begin
        reset = 1'b1;
        lframe = 1'b0;
        rframe = 1'b0;
        lb.src_valid = '0; lb.src_done = '0; lb.src_color = '0;
        lb.src_x = '0; lb.src_y = '0; lb.src_transparent = '0;
        lb.fb_ready = 1'b1;
        rb.src_valid = '0; rb.src_done = '0; rb.src_color = '0;
        rb.src_x = '0; rb.src_y = '0; rb.src_transparent = '0;
        rb.fb_ready = 1'b1;
        tick(); tick();
        chk("rst_we", 32'(lb.fb_we), 0);
        chk("rst_grant", 32'(lb.src_grant), 0);
        chk("rst_busy", 32'(lbusy), 0);
        chk("rst_fc", 32'(lfc), 0);
        chk("rst_ovr", 32'(lovr), 0);
        chk("rst_wc", 32'(lwc), 0);
        chk("rst_dc", 32'(ldc), 0);
        chk("rst_rr_grant", 32'(rb.src_grant), 0);
        reset = 1'b0;

        // layered painter's order
        lframe = 1'b1; tick(); lframe = 1'b0;
        chk("l_grant0", 32'(lb.src_grant), 1);
        chk("l_busy", 32'(lbusy), 1);
        lpix(0, 0, 0, 9'h1FF, 1'b0); tick();
        chk("l_we_a", 32'(lb.fb_we), 1);
        chk("l_x_a", 32'(lb.fb_x), 0);
        chk("l_y_a", 32'(lb.fb_y), 0);
        chk("l_col_a", 32'(lb.fb_color), 32'h1FF);
        lpix(0, 1, 0, 9'h1FF, 1'b0); tick();
        chk("l_we_b", 32'(lb.fb_we), 1);
        chk("l_x_b", 32'(lb.fb_x), 1);
        lpix(0, 2, 0, 9'h1FF, 1'b0); lb.src_done = 2'b01; tick();
        chk("l_we_c", 32'(lb.fb_we), 1);
        chk("l_x_c", 32'(lb.fb_x), 2);
        chk("l_grant1", 32'(lb.src_grant), 2);
        lb.src_done = '0; lpix(1, 5, 5, 9'h007, 1'b0); tick();
        chk("l_we_d", 32'(lb.fb_we), 1);
        chk("l_x_d", 32'(lb.fb_x), 5);
        chk("l_y_d", 32'(lb.fb_y), 5);
        chk("l_col_d", 32'(lb.fb_color), 32'h007);
        lidle(); lb.src_done = 2'b10; tick();
        chk("l_fc", 32'(lfc), 1);
        chk("l_wc", 32'(lwc), 4);
        chk("l_dc", 32'(ldc), 0);
        chk("l_busy_end", 32'(lbusy), 0);
        chk("l_grant_end", 32'(lb.src_grant), 0);
        chk("l_we_end", 32'(lb.fb_we), 0);
        lb.src_done = '0; tick();
        chk("l_fc_once", 32'(lfc), 0);

        // clipping and transparency
        lframe = 1'b1; tick(); lframe = 1'b0;
        lpix(0, 640, 0, 9'h0F0, 1'b0); tick();
        chk("clip_x", 32'(lb.fb_we), 0);
        lpix(0, 0, 480, 9'h0F0, 1'b0); tick();
        chk("clip_y", 32'(lb.fb_we), 0);
        lpix(0, 10, 10, 9'h0F0, 1'b1); tick();
        chk("transp", 32'(lb.fb_we), 0);
        lidle(); lb.src_done = 2'b01; tick();
        lb.src_done = 2'b10; tick();
        chk("clip_fc", 32'(lfc), 1);
        chk("clip_dc", 32'(ldc), 3);
        chk("clip_wc", 32'(lwc), 0);
        lb.src_done = '0;

        // frame buffer back-pressure
        lframe = 1'b1; tick(); lframe = 1'b0;
        lb.fb_ready = 1'b0;
        lpix(0, 3, 4, 9'h0AA, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_we", 32'(lb.fb_we), 0);
            chk("stall_grant", 32'(lb.src_grant), 1);
        end
        lb.fb_ready = 1'b1; tick();
        chk("resume_we", 32'(lb.fb_we), 1);
        chk("resume_x", 32'(lb.fb_x), 3);
        chk("resume_y", 32'(lb.fb_y), 4);
        lidle(); lb.src_done = 2'b01; tick();
        lb.src_done = 2'b10; tick();
        chk("stall_fc", 32'(lfc), 1);
        chk("stall_wc", 32'(lwc), 1);
        lb.src_done = '0;

        // frame coincident with final done: no overrun
        lframe = 1'b1; tick(); lframe = 1'b0;
        lb.src_done = 2'b01; tick();
        lb.src_done = 2'b10; lframe = 1'b1; tick();
        lframe = 1'b0; lb.src_done = '0;
        chk("coin_fc", 32'(lfc), 1);
        chk("coin_ovr", 32'(lovr), 0);
        chk("coin_busy", 32'(lbusy), 1);
        chk("coin_grant", 32'(lb.src_grant), 1);

        // overrun while serving source 1
        lpix(0, 1, 1, 9'h011, 1'b0); tick();
        chk("ovr_we0", 32'(lb.fb_we), 1);
        lidle(); lb.src_done = 2'b01; tick();
        lb.src_done = '0;
        chk("ovr_grant1", 32'(lb.src_grant), 2);
        lpix(1, 2, 2, 9'h022, 1'b0); tick();
        chk("ovr_x1", 32'(lb.fb_x), 2);
        lidle(); lframe = 1'b1; tick(); lframe = 1'b0;
        chk("ovr_flag", 32'(lovr), 1);
        chk("ovr_grant0", 32'(lb.src_grant), 1);
        chk("ovr_nofc", 32'(lfc), 0);
        lpix(0, 7, 7, 9'h077, 1'b0); tick();
        chk("ovr_x7", 32'(lb.fb_x), 7);
        lidle(); lb.src_done = 2'b01; tick();
        lb.src_done = 2'b10; tick();
        chk("ovr_fc", 32'(lfc), 1);
        chk("ovr_wc", 32'(lwc), 1);
        chk("ovr_dc", 32'(ldc), 0);
        chk("ovr_sticky", 32'(lovr), 1);
        lb.src_done = '0;

        // reset mid-sequence with a coincident accept
        lframe = 1'b1; tick(); lframe = 1'b0;
        lpix(0, 4, 4, 9'h044, 1'b0); reset = 1'b1; tick();
        chk("mrst_we", 32'(lb.fb_we), 0);
        chk("mrst_grant", 32'(lb.src_grant), 0);
        chk("mrst_busy", 32'(lbusy), 0);
        chk("mrst_ovr", 32'(lovr), 0);
        chk("mrst_wc", 32'(lwc), 0);
        chk("mrst_dc", 32'(ldc), 0);
        reset = 1'b0; lidle();

        // round robin over sources 0, 2, 3
        for (int k = 0; k < 4; k++) begin
            rb.src_x[k*11 +: 11] = 11'(k);
            rb.src_y[k*11 +: 11] = 11'(k + 8);
            rb.src_color[k*9 +: 9] = 9'(k + 16);
        end
        rb.src_valid = 4'b1101;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_grant", 32'(rb.src_grant), 32'(exp_g[k]));
            if (k == 0) begin
                chk("rr_we0", 32'(rb.fb_we), 0);
            end else begin
                chk("rr_we", 32'(rb.fb_we), 1);
                chk("rr_x", 32'(rb.fb_x), 32'(exp_i[k-1]));
                chk("rr_y", 32'(rb.fb_y), 32'(exp_i[k-1] + 8));
                chk("rr_col", 32'(rb.fb_color), 32'(exp_i[k-1] + 16));
            end
        end
        rb.src_valid = '0; rframe = 1'b1; tick(); rframe = 1'b0;
        chk("rr_fc", 32'(rfc), 1);
        chk("rr_wc", 32'(rwc), 7);
        chk("rr_dc", 32'(rdc), 0);
        chk("rr_busy", 32'(rbusy), 0);
        chk("rr_grant_none", 32'(rb.src_grant), 0);
        tick();
        chk("rr_fc_once", 32'(rfc), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- N-source write arbiter between the draw units (background, starfield, sprites, ...) and the frame buffer single write port.
- Generalises the fixed single-selector scheme to NUM_SOURCES sources with two modes:
  - LAYERED: per-frame painter's order, source 0 first.
  - ROUND_ROBIN: continuous fair sharing.
- Adds transparency drop, screen-bounds clipping, a frame-overrun flag and per-frame write/drop counters.
- Sits in the clk_25 domain between the draw units and the frame manager write port.

Parameters:
NUM_SOURCES, 4, number of draw sources (2..16)
COLOR_DEPTH, 9, color word width
COORD_W, 11, x/y coordinate width
SCREEN_W, 640, pixels per line; x >= SCREEN_W is clipped
SCREEN_H, 480, lines; y >= SCREEN_H is clipped
MODE, 0, 0 = LAYERED, 1 = ROUND_ROBIN

Ports:
clk  in  1  system clock (clk_25 domain)
reset  in  1  synchronous, active-high reset
frame  in  1  one-cycle start-of-frame pulse
fb_ready  in  1  frame buffer can take a write next cycle
src_valid  in  NUM_SOURCES  source k presents a pixel
src_done  in  NUM_SOURCES  source k finished its frame (LAYERED only)
src_color  in  NUM_SOURCES*COLOR_DEPTH  packed colors; source k at [k*COLOR_DEPTH +: COLOR_DEPTH]
src_x  in  NUM_SOURCES*COORD_W  packed x coordinates
src_y  in  NUM_SOURCES*COORD_W  packed y coordinates
src_transparent  in  NUM_SOURCES  pixel is to be discarded
src_grant  out  NUM_SOURCES  one-hot (or zero) grant, registered
fb_we  out  1  write strobe, one cycle per write
fb_x  out  COORD_W  write x
fb_y  out  COORD_W  write y
fb_color  out  COLOR_DEPTH  write data
busy  out  1  LAYERED sequence in progress
frame_complete  out  1  one-cycle pulse when the last layer finishes
overrun  out  1  sticky; frame arrived while busy
write_count  out  16  committed writes in the last completed frame
drop_count  out  16  transparent or clipped pixels in the last completed frame

Behaviour:
- Reset values (synchronous, takes priority over everything): all outputs 0, grant pointer 0, state IDLE, internal counters 0. A reset in the middle of a sequence aborts it, and no fb_we is produced on the following cycle.
- accept = src_valid[k] & src_grant[k] & fb_ready. At most one accept per cycle. Sources must hold their data until accepted.
- Output register, latency 1 cycle:
  - Cycle after accept: fb_we = 1 with the accepted x, y and color, provided the pixel is not transparent and x < SCREEN_W and y < SCREEN_H.
  - Otherwise fb_we = 0 and the drop counter increments.
  - The frame buffer must take every fb_we pulse.
- LAYERED FSM (MODE = 0), states IDLE, SERVE:
  - IDLE: grant = 0. On frame: cur = 0, grant = onehot(0), go to SERVE, busy = 1.
  - SERVE: on src_done[cur] & grant[cur]:
    - If cur < NUM_SOURCES-1: cur++, grant moves next cycle. The done cycle may coincide with an accept; that accept is honoured.
    - If cur = NUM_SOURCES-1: go to IDLE, grant = 0, frame_complete pulse, write_count and drop_count latch the internal counters, internal counters clear.
  - frame while in SERVE: overrun = 1 (sticky until reset). Restart at cur = 0; internal counters clear without latching.
  - frame in the same cycle as the final done: the final done completes (pulse and latch), then a new sequence starts immediately; no overrun.
  - src_done is ignored for non-granted sources.
- ROUND_ROBIN (MODE = 1):
  - frame input and src_done are ignored for sequencing; busy = 0.
  - Grant is recomputed each cycle for the following cycle. Search starts at (last_accepted + 1) mod NUM_SOURCES and picks the first source with src_valid high.
  - The grant is held while the granted source stays valid and no accept has occurred.
  - No valid sources: grant = 0.
  - Pointer wraps from NUM_SOURCES-1 to 0.
  - Counters latch on each frame pulse; frame_complete pulses on that same cycle.
- Counters saturate at 16'hFFFF.
- Coordinates are compared unsigned.

Test Plan:
- LAYERED, NUM_SOURCES=2: reset, frame; src0 sends 3 pixels ((0,0), (1,0), (2,0), color 9'h1FF) then done; src1 sends (5,5) with color 9'h007 then done. Required: fb_we at those 4 coordinates in order, each 1 cycle after its accept; frame_complete once; write_count=4, drop_count=0.
- Clipping and transparency: pixels at x=640; y=480; and (10,10) with transparent=1. Required: no fb_we for any of them; drop_count=3.
- fb_ready=0 for 5 cycles with src0 valid. Required: no accept, no fb_we, grant held on src0. Writes resume on the cycle after fb_ready returns to 1.
- Overrun: second frame pulse while cur=1. Required: overrun=1 and stays 1; grant returns to src0 next cycle; the next frame_complete latches counts from the restarted sequence only.
- ROUND_ROBIN, NUM_SOURCES=4: sources 0, 2, 3 continuously valid. Required: grant sequence 0, 2, 3, 0, 2, ... one accept each; source 1 is never granted.
- Reset asserted mid-SERVE with an accept on the same cycle. Required: next cycle fb_we=0, grant=0, busy=0, overrun=0, all counters 0.
